bf16_out_serializer: RTL

BF16_OUT_SERIALIZER -- requirements
Module: bf16_out_serializer

---
 rtl/tpu_pkg.sv | 6 +
 rtl/bf16_out_serializer.sv | 97 +++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared bf16 type, serializer state encoding and byte-count constant
package tpu_pkg;
  typedef logic [15:0] bf16_t;
  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_CSUM} ser_state_e;
  localparam int BF16_BYTES = 2;
endpackage

// File: rtl/bf16_out_serializer.sv
// bf16_out_serializer: collects NUM_WORDS bf16 words, then streams them out as bytes
// Optional BF16_SER_CSUM_EN appends an XOR checksum byte to every block.
module bf16_out_serializer
  import tpu_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);
  localparam int NB = BF16_BYTES * NUM_WORDS;
  localparam int WW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int BW = $clog2(NB);
  ser_state_e state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  bf16_t buf_q [2**WW];
  bf16_t word_sel;
  logic [7:0] byte_sel;
  logic acc, snd, last_word, last_byte, hi;
`ifdef BF16_SER_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  always_comb begin
    in_ready = !rst && state_q == S_FILL;
    busy = !rst && state_q != S_FILL;
    out_valid = busy;
    word_sel = buf_q[WW'(bcnt_q >> 1)];
    hi = (bcnt_q[0] == 1'b0) == MSB_FIRST;
    byte_sel = hi ? word_sel[15:8] : word_sel[7:0];
    last_word = wcnt_q == WW'(NUM_WORDS - 1);
    last_byte = bcnt_q == BW'(NB - 1);
`ifdef BF16_SER_CSUM_EN
    out_data = !busy ? 8'h00 : state_q == S_CSUM ? csum_q : byte_sel;
    out_last = busy && state_q == S_CSUM;
`else
    out_data = busy ? byte_sel : 8'h00;
    out_last = busy && last_byte;
`endif
    acc = in_valid && in_ready;
    snd = out_valid && out_ready;
    state_d = state_q;
    wcnt_d = wcnt_q;
    bcnt_d = bcnt_q;
`ifdef BF16_SER_CSUM_EN
    csum_d = !snd ? csum_q : state_q == S_CSUM ? 8'h00 : csum_q ^ byte_sel;
`endif
    case (state_q)
      S_FILL: if (acc) begin
        wcnt_d = last_word ? '0 : wcnt_q + WW'(1);
        state_d = last_word ? S_DRAIN : S_FILL;
      end
      S_DRAIN: if (snd) begin
        bcnt_d = last_byte ? '0 : bcnt_q + BW'(1);
`ifdef BF16_SER_CSUM_EN
        state_d = last_byte ? S_CSUM : S_DRAIN;
`else
        state_d = last_byte ? S_FILL : S_DRAIN;
`endif
      end
`ifdef BF16_SER_CSUM_EN
      S_CSUM: if (snd) state_d = S_FILL;
`endif
      default: state_d = S_FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      wcnt_q <= '0;
      bcnt_q <= '0;
`ifdef BF16_SER_CSUM_EN
      csum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      bcnt_q <= bcnt_d;
`ifdef BF16_SER_CSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  // Buffer contents are only read in DRAIN after a full fill, so no reset is needed.
  always_ff @(posedge clk) begin
    if (acc) buf_q[wcnt_q] <= in_data;
  end
endmodule
